// File: rtl/accum_buffer_pkg.sv
// Shared constants and FSM encoding for the ping-pong partial-sum accumulation buffer.
package accum_buffer_pkg;
  localparam int DEF_NUM_COLS    = 4;
  localparam int DEF_OFMAP_WIDTH = 8;
  localparam int DEF_ACC_WIDTH   = 16;
  localparam int DEF_DEPTH       = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;
endpackage

// File: rtl/accum_bank.sv
// One accumulation bank: per-lane sign-extend then overwrite or wrap-add on write,
// combinational read port.
module accum_bank
  import accum_buffer_pkg::*;
#(
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int OFMAP_WIDTH = DEF_OFMAP_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic                            wr_first,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [NUM_COLS*OFMAP_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [NUM_COLS*ACC_WIDTH-1:0]   rd_data
);
  logic [ACC_WIDTH-1:0] mem_q [DEPTH][NUM_COLS];
  logic [ACC_WIDTH-1:0] mem_d [DEPTH][NUM_COLS];
  logic signed [OFMAP_WIDTH-1:0] lane_in;
  logic [ACC_WIDTH-1:0] lane_ext;

  always_comb begin
    mem_d    = mem_q;
    lane_in  = '0;
    lane_ext = '0;
    if (wr_en) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        lane_in  = wr_data[c*OFMAP_WIDTH +: OFMAP_WIDTH];
        lane_ext = ACC_WIDTH'(lane_in);
        // Adds wrap modulo 2^ACC_WIDTH on purpose; no saturation.
        mem_d[wr_addr][c] = wr_first ? lane_ext : mem_q[wr_addr][c] + lane_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          mem_q[e][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      rd_data[c*ACC_WIDTH +: ACC_WIDTH] = mem_q[rd_addr][c];
    end
  end
endmodule

// File: rtl/accum_buffer.sv
// Double-buffered accumulator: the array writes one bank while the other drains
// through a valid/ready stream; a swap request exchanges the banks.
module accum_buffer
  import accum_buffer_pkg::*;
#(
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int OFMAP_WIDTH = DEF_OFMAP_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_first,
  input  logic [ADDR_WIDTH:0]             in_addr,
  input  logic [NUM_COLS*OFMAP_WIDTH-1:0] in_data,
  input  logic                            swap,
  output logic                            swap_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_COLS*ACC_WIDTH-1:0]   out_data,
  output logic                            out_last,
  output logic                            wr_err,
  output logic                            swap_err
);
  state_e                state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  wr_err_q, wr_err_d;
  logic                  swap_err_q, swap_err_d;

  logic                           in_range;
  logic                           at_last;
  logic [NUM_COLS*ACC_WIDTH-1:0]  rd_data0, rd_data1;

  assign in_range = in_addr < (ADDR_WIDTH+1)'(DEPTH);
  assign at_last  = rd_ptr_q == ADDR_WIDTH'(DEPTH-1);

  // Writes follow the registered wr_bank, so a write coinciding with a swap
  // lands in the bank that is about to be drained.
  accum_bank #(
    .NUM_COLS(NUM_COLS), .OFMAP_WIDTH(OFMAP_WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH)
  ) u_bank0 (
    .clk(clk), .rst(rst),
    .wr_en(in_valid && in_range && !wr_bank_q), .wr_first(in_first),
    .wr_addr(in_addr[ADDR_WIDTH-1:0]), .wr_data(in_data),
    .rd_addr(rd_ptr_q), .rd_data(rd_data0)
  );

  accum_bank #(
    .NUM_COLS(NUM_COLS), .OFMAP_WIDTH(OFMAP_WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH)
  ) u_bank1 (
    .clk(clk), .rst(rst),
    .wr_en(in_valid && in_range && wr_bank_q), .wr_first(in_first),
    .wr_addr(in_addr[ADDR_WIDTH-1:0]), .wr_data(in_data),
    .rd_addr(rd_ptr_q), .rd_data(rd_data1)
  );

  assign out_data   = wr_bank_q ? rd_data0 : rd_data1;
  assign out_valid  = out_valid_q;
  assign out_last   = out_valid_q && at_last;
  assign swap_ready = state_q == ST_IDLE;
  assign wr_err     = wr_err_q;
  assign swap_err   = swap_err_q;

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    wr_err_d    = in_valid && !in_range;
    swap_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (swap) begin
          state_d     = ST_DRAIN;
          wr_bank_d   = ~wr_bank_q;
          rd_ptr_d    = '0;
          out_valid_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        swap_err_d = swap;
        if (out_valid_q && out_ready) begin
          if (at_last) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            rd_ptr_d    = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      wr_err_q    <= 1'b0;
      swap_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      wr_err_q    <= wr_err_d;
      swap_err_q  <= swap_err_d;
    end
  end
endmodule
